// File: rtl/ag_tcu_dispatch_pkg.sv
// Shared types and defaults for the AG TCU issue-side dispatch block:
// issue/execute packet layouts, credit limits and the drain FSM states.
package ag_tcu_dispatch_pkg;

  localparam int AG_TCU_NUM_WARPS     = 8;
  localparam int AG_TCU_NW_WIDTH      = (AG_TCU_NUM_WARPS > 1) ? $clog2(AG_TCU_NUM_WARPS) : 1;
  localparam int AG_TCU_MAX_INFLIGHT  = 8;
  localparam int AG_TCU_MAX_PER_WARP  = 4;
  localparam int AG_TCU_PERF_CTR_BITS = 32;

  typedef logic [AG_TCU_NW_WIDTH-1:0] ag_tcu_wid_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } ag_tcu_state_e;

  // Instruction as delivered by the issue stage.
  typedef struct packed {
    logic [7:0]  uuid;
    ag_tcu_wid_t wid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } ag_tcu_issue_t;

  typedef struct packed {
    logic [7:0] scale_a;
    logic [7:0] scale_b;
  } ag_tcu_args_t;

  typedef struct packed {
    ag_tcu_args_t tcu;
  } ag_tcu_op_args_t;

  // Packet handed to the tensor-core execute stage.
  typedef struct packed {
    logic [7:0]      uuid;
    ag_tcu_wid_t     wid;
    logic [31:0]     pc;
    logic [4:0]      rd;
    logic [31:0]     rs1_data;
    logic [31:0]     rs2_data;
    ag_tcu_op_args_t op_args;
  } ag_tcu_exe_t;

  // Field-for-field copy; the shared exponents pass through untouched.
  function automatic ag_tcu_exe_t pack_exe(input ag_tcu_issue_t iss,
                                           input logic [7:0]    scale_a,
                                           input logic [7:0]    scale_b);
    ag_tcu_exe_t e;
    e.uuid                = iss.uuid;
    e.wid                 = iss.wid;
    e.pc                  = iss.pc;
    e.rd                  = iss.rd;
    e.rs1_data            = iss.rs1_data;
    e.rs2_data            = iss.rs2_data;
    e.op_args.tcu.scale_a = scale_a;
    e.op_args.tcu.scale_b = scale_b;
    return e;
  endfunction

endpackage

// File: rtl/ag_tcu_dispatch_credit_tracker.sv
// Global and per-warp in-flight counters for the AG TCU. Issue consumes a
// credit, a result commit returns one; a commit for an idle warp is flagged.
module ag_tcu_dispatch_credit_tracker
  import ag_tcu_dispatch_pkg::*;
#(
  parameter int MAX_INFLIGHT = AG_TCU_MAX_INFLIGHT,
  parameter int MAX_PER_WARP = AG_TCU_MAX_PER_WARP
) (
  input  logic                        clk,
  input  logic                        reset,
  input  ag_tcu_wid_t                 i_query_wid,
  output logic                        o_can_issue,
  input  logic                        i_issue_fire,
  input  ag_tcu_wid_t                 i_issue_wid,
  input  logic                        i_commit_fire,
  input  ag_tcu_wid_t                 i_commit_wid,
  output logic                        o_total_zero,
  output logic [AG_TCU_NUM_WARPS-1:0] o_warp_busy,
  output logic                        o_credit_err
);

  localparam int TW = $clog2(MAX_INFLIGHT) + 1;
  localparam int WW = $clog2(MAX_PER_WARP) + 1;

  logic [TW-1:0]               r_total;
  logic [WW-1:0]               r_warp_cnt [AG_TCU_NUM_WARPS];
  logic                        r_credit_err;
  logic                        w_commit_ok;
  logic [AG_TCU_NUM_WARPS-1:0] w_inc;
  logic [AG_TCU_NUM_WARPS-1:0] w_dec;

  // Decode which warp gains and which loses a credit this cycle.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_inc       = '0;
    w_dec       = '0;
    w_commit_ok = i_commit_fire && (r_warp_cnt[i_commit_wid] != '0);
    for (int w = 0; w < AG_TCU_NUM_WARPS; w++) begin
      w_inc[w] = i_issue_fire && (i_issue_wid == ag_tcu_wid_t'(w));
      w_dec[w] = w_commit_ok && (i_commit_wid == ag_tcu_wid_t'(w));
    end
  end

  // Counter update; simultaneous +1/-1 on the same counter cancels out.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_total <= '0;
      for (int w = 0; w < AG_TCU_NUM_WARPS; w++) r_warp_cnt[w] <= '0;
    end else begin
      case ({i_issue_fire, w_commit_ok})
        2'b10:   r_total <= r_total + TW'(1);
        2'b01:   r_total <= r_total - TW'(1);
        default: ;
      endcase
      for (int w = 0; w < AG_TCU_NUM_WARPS; w++) begin
        case ({w_inc[w], w_dec[w]})
          2'b10:   r_warp_cnt[w] <= r_warp_cnt[w] + WW'(1);
          2'b01:   r_warp_cnt[w] <= r_warp_cnt[w] - WW'(1);
          default: ;
        endcase
      end
    end
  end

  // Sticky flag for a commit arriving on a warp with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset)                             r_credit_err <= 1'b0;
    else if (i_commit_fire && !w_commit_ok) r_credit_err <= 1'b1;
  end

  // Busy bits and limit check come straight from the registered counters.
  always_comb begin
    for (int w = 0; w < AG_TCU_NUM_WARPS; w++) o_warp_busy[w] = (r_warp_cnt[w] != '0);
  end

  assign o_can_issue  = (r_total < TW'(MAX_INFLIGHT)) &&
                        (r_warp_cnt[i_query_wid] < WW'(MAX_PER_WARP));
  assign o_total_zero = (r_total == '0);
  assign o_credit_err = r_credit_err;

endmodule

// File: rtl/ag_tcu_dispatch.sv
// AG TCU issue-side transmitter: packs scale exponents into the execute
// packet, buffers it in a 2-entry elastic stage, enforces in-flight credits
// and runs the RUN/DRAIN/HOLD drain sequence.
// Optional: define AG_TCU_DISPATCH_PERF_EN to add perf_issued/perf_stalls.
module ag_tcu_dispatch
  import ag_tcu_dispatch_pkg::*;
#(
  parameter int MAX_INFLIGHT  = AG_TCU_MAX_INFLIGHT,
  parameter int MAX_PER_WARP  = AG_TCU_MAX_PER_WARP,
  parameter int PERF_CTR_BITS = AG_TCU_PERF_CTR_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  ag_tcu_issue_t               issue_data,
  input  logic [7:0]                  issue_scale_a,
  input  logic [7:0]                  issue_scale_b,
  output logic                        issue_ready,
  output logic                        execute_valid,
  output ag_tcu_exe_t                 execute_data,
  input  logic                        execute_ready,
  input  logic                        commit_fire,
  input  ag_tcu_wid_t                 commit_wid,
  input  logic                        drain_req,
  output logic                        drain_done,
  output logic [AG_TCU_NUM_WARPS-1:0] warp_busy,
  output logic                        credit_err
`ifdef AG_TCU_DISPATCH_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]    perf_issued,
  output logic [PERF_CTR_BITS-1:0]    perf_stalls
`endif
);

  ag_tcu_state_e r_state, w_state_next;
  logic          w_drain_done;
  logic          w_can_issue;
  logic          w_total_zero;
  logic          w_push, w_pop;
  logic          w_buf_full, w_buf_empty;

  ag_tcu_exe_t   r_buf [2];
  logic          r_rd_ptr, r_wr_ptr;
  logic [1:0]    r_count;

  ag_tcu_dispatch_credit_tracker #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .MAX_PER_WARP (MAX_PER_WARP)
  ) u_credit (
    .clk           (clk),
    .reset         (reset),
    .i_query_wid   (issue_data.wid),
    .o_can_issue   (w_can_issue),
    .i_issue_fire  (w_push),
    .i_issue_wid   (issue_data.wid),
    .i_commit_fire (commit_fire),
    .i_commit_wid  (commit_wid),
    .o_total_zero  (w_total_zero),
    .o_warp_busy   (warp_busy),
    .o_credit_err  (credit_err)
  );

  assign w_buf_full  = (r_count == 2'd2);
  assign w_buf_empty = (r_count == 2'd0);

  // A drain request blocks issue in the same cycle it is raised.
  assign issue_ready = !reset && (r_state == ST_RUN) && !drain_req &&
                       !w_buf_full && w_can_issue;
  assign w_push      = issue_valid && issue_ready;
  assign w_pop       = !w_buf_empty && execute_ready;

  // Elastic stage pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
    end
  end

  // Elastic stage storage, written with the packed execute packet.
  // NOTE: payload storage is not reset; occupancy is, so stale entries are never presented.
  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= pack_exe(issue_data, issue_scale_a, issue_scale_b);
  end

  assign execute_valid = !w_buf_empty;
  assign execute_data  = r_buf[r_rd_ptr];

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  // Drain FSM next-state and completion pulse.
  always_comb begin
    w_state_next = r_state;
    w_drain_done = 1'b0;
    case (r_state)
      ST_RUN:   if (drain_req) w_state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (w_buf_empty && w_total_zero) begin
          w_drain_done = 1'b1;
          w_state_next = drain_req ? ST_HOLD : ST_RUN;
        end
      end
      ST_HOLD:  if (!drain_req) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  assign drain_done = w_drain_done && !reset;

`ifdef AG_TCU_DISPATCH_PERF_EN
  logic [PERF_CTR_BITS-1:0] r_perf_issued, r_perf_stalls;
  logic                     w_credit_stall;

  // Stall counted only when credits are the sole reason issue is refused.
  assign w_credit_stall = issue_valid && !reset && (r_state == ST_RUN) &&
                          !drain_req && !w_buf_full && !w_can_issue;

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_issued <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_pop)          r_perf_issued <= r_perf_issued + PERF_CTR_BITS'(1);
      if (w_credit_stall) r_perf_stalls <= r_perf_stalls + PERF_CTR_BITS'(1);
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_ag_tcu_dispatch.sv
// Scoreboard bench for ag_tcu_dispatch: the driver pushes the expected
// execute packet on every accepted issue; a monitor pops and compares on
// every execute handshake and checks the head packet while stalled.
module tb_ag_tcu_dispatch;
  import ag_tcu_dispatch_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  ag_tcu_issue_t issue_data;
  logic [7:0]    issue_scale_a, issue_scale_b;
  logic          issue_ready;
  logic          execute_valid;
  ag_tcu_exe_t   execute_data;
  logic          execute_ready;
  logic          commit_fire;
  ag_tcu_wid_t   commit_wid;
  logic          drain_req;
  logic          drain_done;
  logic [7:0]    warp_busy;
  logic          credit_err;
`ifdef AG_TCU_DISPATCH_PERF_EN
  logic [31:0]   perf_issued, perf_stalls;
`endif

  ag_tcu_exe_t sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  uuid_ctr = 8'd0;
  bit          acc;

  always #5 clk = ~clk;

  ag_tcu_dispatch dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_data    (issue_data),
    .issue_scale_a (issue_scale_a),
    .issue_scale_b (issue_scale_b),
    .issue_ready   (issue_ready),
    .execute_valid (execute_valid),
    .execute_data  (execute_data),
    .execute_ready (execute_ready),
    .commit_fire   (commit_fire),
    .commit_wid    (commit_wid),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .warp_busy     (warp_busy),
    .credit_err    (credit_err)
`ifdef AG_TCU_DISPATCH_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_stalls   (perf_stalls)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ag_tcu_issue_t mk_issue(input logic [2:0] wid, input logic [7:0] uuid);
    ag_tcu_issue_t s;
    s.uuid     = uuid;
    s.wid      = wid;
    s.pc       = 32'h0000_1000 + {22'd0, uuid, 2'b00};
    s.rd       = uuid[4:0];
    s.rs1_data = {24'hA5A5A5, uuid};
    s.rs2_data = {24'h5A5A5A, ~uuid};
    return s;
  endfunction

  function automatic ag_tcu_exe_t expect_exe(input ag_tcu_issue_t s, input logic [7:0] sa,
                                             input logic [7:0] sb);
    ag_tcu_exe_t e;
    e.uuid                = s.uuid;
    e.wid                 = s.wid;
    e.pc                  = s.pc;
    e.rd                  = s.rd;
    e.rs1_data            = s.rs1_data;
    e.rs2_data            = s.rs2_data;
    e.op_args.tcu.scale_a = sa;
    e.op_args.tcu.scale_b = sb;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for up to max_wait cycles; record expectation on accept.
  task automatic do_issue(input logic [2:0] wid, input logic [7:0] sa, input logic [7:0] sb,
                          input int max_wait, output bit accepted);
    accepted      = 1'b0;
    issue_data    = mk_issue(wid, uuid_ctr);
    issue_scale_a = sa;
    issue_scale_b = sb;
    issue_valid   = 1'b1;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (issue_ready) begin
        sb_q.push_back(expect_exe(issue_data, sa, sb));
        accepted = 1'b1;
      end
      step();
      if (accepted) break;
    end
    issue_valid = 1'b0;
    uuid_ctr    = uuid_ctr + 8'd1;
  endtask

  task automatic do_commit(input logic [2:0] wid);
    commit_fire = 1'b1;
    commit_wid  = wid;
    step();
    commit_fire = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      step();
    end
    check("sb_drained", 128'(sb_q.size()), 128'd0);
  endtask

  // Monitor: compare on handshake, check head stability while stalled.
  always @(negedge clk) begin
    if (!reset && execute_valid) begin
      if (sb_q.size() == 0) begin
        if (execute_ready) begin
          n_checks++;
          n_errors++;
          $display("FAIL exe_unexpected: got 0x%0h expected no packet", execute_data);
        end
      end else if (execute_ready) begin
        check("exe_pkt", execute_data, sb_q.pop_front());
      end else begin
        check("exe_stable", execute_data, sb_q[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    issue_valid   = 1'b0;
    issue_data    = '0;
    issue_scale_a = '0;
    issue_scale_b = '0;
    execute_ready = 1'b0;
    commit_fire   = 1'b0;
    commit_wid    = '0;
    drain_req     = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_issue_ready", 128'(issue_ready), 128'd0);
    check("rst_exe_valid", 128'(execute_valid), 128'd0);
    check("rst_drain_done", 128'(drain_done), 128'd0);
    check("rst_credit_err", 128'(credit_err), 128'd0);
    check("rst_warp_busy", 128'(warp_busy), 128'd0);
    step();
    reset         = 1'b0;
    execute_ready = 1'b1;
    @(negedge clk);
    check("idle_ready", 128'(issue_ready), 128'd1);
    step();

    // 1: single issue, one-cycle latency, scales copied, busy tracking.
    do_issue(3'd2, 8'h7F, 8'h81, 4, acc);
    check("t1_acc", 128'(acc), 128'd1);
    @(negedge clk);
    check("t1_exe_valid", 128'(execute_valid), 128'd1);
    check("t1_scale_a", 128'(execute_data.op_args.tcu.scale_a), 128'h7F);
    check("t1_scale_b", 128'(execute_data.op_args.tcu.scale_b), 128'h81);
    check("t1_busy", 128'(warp_busy), 128'h04);
    step();
    do_commit(3'd2);
    @(negedge clk);
    check("t1_busy_clr", 128'(warp_busy), 128'h00);
    step();

    // 2: per-warp cap of 4 on wid 1; other warps unaffected.
    for (int i = 0; i < 4; i++) begin
      do_issue(3'd1, 8'h10 + 8'(i), 8'h20 + 8'(i), 4, acc);
      check("t2_acc", 128'(acc), 128'd1);
    end
    do_issue(3'd1, 8'h33, 8'h44, 3, acc);
    check("t2_fifth_held", 128'(acc), 128'd0);
    do_issue(3'd3, 8'h55, 8'h66, 3, acc);
    check("t2_other_warp", 128'(acc), 128'd1);
    wait_empty(20);
    @(negedge clk);
    check("t2_busy", 128'(warp_busy), 128'h0A);
    step();
    for (int i = 0; i < 4; i++) do_commit(3'd1);
    do_commit(3'd3);
    @(negedge clk);
    check("t2_busy_clr", 128'(warp_busy), 128'h00);
    step();

    // 3: backpressure fills the buffer; release delivers all 8 in order.
    execute_ready = 1'b0;
    do_issue(3'd0, 8'h10, 8'h20, 3, acc);
    check("t3_acc0", 128'(acc), 128'd1);
    do_issue(3'd1, 8'h11, 8'h21, 3, acc);
    check("t3_acc1", 128'(acc), 128'd1);
    do_issue(3'd2, 8'h12, 8'h22, 2, acc);
    check("t3_full_blocks", 128'(acc), 128'd0);
    fork
      begin
        repeat (3) step();
        execute_ready = 1'b1;
      end
      begin
        for (int w = 2; w < 8; w++) begin
          do_issue(3'(w), 8'h10 + 8'(w), 8'h20 + 8'(w), 20, acc);
          check("t3_acc_rest", 128'(acc), 128'd1);
        end
      end
    join
    wait_empty(40);
    @(negedge clk);
    check("t3_all_busy", 128'(warp_busy), 128'hFF);
    step();
    do_issue(3'd0, 8'h99, 8'h98, 3, acc);
    check("t3_ninth_blocked", 128'(acc), 128'd0);
    do_commit(3'd7);
    do_issue(3'd0, 8'h99, 8'h98, 3, acc);
    check("t3_ninth_after_commit", 128'(acc), 128'd1);
    wait_empty(20);

    // 4: same-cycle issue and commit on wid 0 holding 2 credits.
    for (int w = 1; w < 7; w++) do_commit(3'(w));
    issue_data    = mk_issue(3'd0, uuid_ctr);
    issue_scale_a = 8'hC3;
    issue_scale_b = 8'h3C;
    issue_valid   = 1'b1;
    commit_fire   = 1'b1;
    commit_wid    = 3'd0;
    @(negedge clk);
    check("t4_ready", 128'(issue_ready), 128'd1);
    if (issue_ready) sb_q.push_back(expect_exe(issue_data, 8'hC3, 8'h3C));
    step();
    issue_valid = 1'b0;
    commit_fire = 1'b0;
    uuid_ctr    = uuid_ctr + 8'd1;
    wait_empty(20);
    do_commit(3'd0);
    @(negedge clk);
    check("t4_cnt_after_one", 128'(warp_busy), 128'h01);
    step();
    do_commit(3'd0);
    @(negedge clk);
    check("t4_cnt_after_two", 128'(warp_busy), 128'h00);
    check("t4_no_err", 128'(credit_err), 128'd0);
    step();

    // 5: drain with 3 in flight; single done pulse; resume afterwards.
    for (int w = 1; w < 4; w++) begin
      do_issue(3'(w), 8'h40, 8'h41, 4, acc);
      check("t5_acc", 128'(acc), 128'd1);
    end
    wait_empty(20);
    drain_req = 1'b1;
    @(negedge clk);
    check("t5_ready_drop", 128'(issue_ready), 128'd0);
    check("t5_no_done_yet", 128'(drain_done), 128'd0);
    step();
    for (int w = 1; w < 4; w++) begin
      commit_fire = 1'b1;
      commit_wid  = 3'(w);
      @(negedge clk);
      check("t5_no_early_done", 128'(drain_done), 128'd0);
      step();
    end
    commit_fire = 1'b0;
    @(negedge clk);
    check("t5_done_pulse", 128'(drain_done), 128'd1);
    step();
    @(negedge clk);
    check("t5_single_pulse", 128'(drain_done), 128'd0);
    check("t5_hold_blocks", 128'(issue_ready), 128'd0);
    step();
    drain_req = 1'b0;
    do_issue(3'd4, 8'h50, 8'h51, 4, acc);
    check("t5_resume", 128'(acc), 128'd1);
    wait_empty(20);
    do_commit(3'd4);

    // 6: commit on idle warp sets sticky error, counters untouched.
    do_commit(3'd5);
    @(negedge clk);
    check("t6_err_set", 128'(credit_err), 128'd1);
    check("t6_cnt_unchanged", 128'(warp_busy), 128'h00);
    step();
    repeat (3) step();
    @(negedge clk);
    check("t6_err_sticky", 128'(credit_err), 128'd1);
    step();
    do_issue(3'd5, 8'h60, 8'h61, 4, acc);
    check("t6_acc", 128'(acc), 128'd1);
    wait_empty(20);
    @(negedge clk);
    check("t6_no_underflow", 128'(warp_busy), 128'h20);
    step();
    do_commit(3'd5);
    @(negedge clk);
    check("t6_busy_clr", 128'(warp_busy), 128'h00);
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t6_err_cleared", 128'(credit_err), 128'd0);
    check("t6_post_rst_ready", 128'(issue_ready), 128'd1);
    check("t6_post_rst_valid", 128'(execute_valid), 128'd0);
    step();

    check("final_sb_empty", 128'(sb_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
